// File: rtl/player_cfg_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | player_cfg_pkg : state encoding and write-address map for the sequencer |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package player_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int NUM_POS = 5;

  localparam logic [2:0] ADDR_G     = 3'd0;
  localparam logic [2:0] ADDR_R     = 3'd1;
  localparam logic [2:0] ADDR_Y     = 3'd2;
  localparam logic [2:0] ADDR_B     = 3'd3;
  localparam logic [2:0] ADDR_O     = 3'd4;
  localparam logic [2:0] ADDR_DELAY = 3'd5;
  localparam logic [2:0] ADDR_STRUM = 3'd6;
  localparam logic [2:0] ADDR_RSVD  = 3'd7;

  // {2'b0, y[9:0], 1'b0, x[10:0]}
  localparam logic [23:0] POS_MASK = 24'h3FF7FF;

endpackage
`default_nettype wire

// File: rtl/player_cfg_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | player_cfg_sequencer_if : shadow-bank write port and commit request     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface player_cfg_sequencer_if;
  logic        WrValid;
  logic        WrReady;
  logic [2:0]  WrAddr;
  logic [23:0] WrData;
  logic        Commit;

  modport master (output WrValid, output WrAddr, output WrData, output Commit, input WrReady);
  modport slave  (input WrValid, input WrAddr, input WrData, input Commit, output WrReady);
endinterface
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sync_edge_detect : two-flop sampler with a rising-edge pulse            |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
endmodule
`default_nettype wire

// File: rtl/player_cfg_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | player_cfg_sequencer : shadow/active config banks applied on frame edge |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module player_cfg_sequencer
  import player_cfg_pkg::*;
#(
  parameter int          SETTLE_FRAMES = 4,
  parameter logic [4:0]  DEF_DELAY     = 5'd0,
  parameter logic [3:0]  DEF_STRUM     = 4'd3,
  parameter int          FCNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  VSync,
  player_cfg_sequencer_if.slave wr,
  input  logic                  EnableReq,
  output logic [23:0]           GreenPos,
  output logic [23:0]           RedPos,
  output logic [23:0]           YellowPos,
  output logic [23:0]           BluePos,
  output logic [23:0]           OrangePos,
  output logic [4:0]            DelayValue,
  output logic [3:0]            StrumTime,
  output logic                  Enable,
  output logic [FCNT_W-1:0]     FrameCount,
  output logic [3:0]            Status
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_FRAMES - 1);

  logic              vs_edge;
  state_t            state;
  state_t            state_nxt;
  logic [3:0]        settle_cnt;
  logic [3:0]        settle_nxt;
  logic              load;
  logic              dirty;
  logic              wr_ready;
  logic              wr_fire;
  logic [23:0]       shadow_pos [NUM_POS];
  logic [23:0]       active_pos [NUM_POS];
  logic [4:0]        shadow_delay;
  logic [3:0]        shadow_strum;
  logic [4:0]        active_delay;
  logic [3:0]        active_strum;
  logic [FCNT_W-1:0] frame_cnt;

  sync_edge_detect u_vs_edge (
    .clk  (CLK),
    .rst  (RST),
    .din  (VSync),
    .rise (vs_edge)
  );

  // The shadow bank is frozen while a commit waits for its frame edge.
  assign wr_ready   = (state != ST_ARMED);
  assign wr_fire    = wr.WrValid & wr_ready;
  assign wr.WrReady = wr_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  // A commit takes priority over settle progress, so a commit landing on a
  // frame edge is held for the following edge.
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr.Commit) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (vs_edge) begin
          load = 1'b1;
          if (SETTLE_FRAMES == 1) begin
            state_nxt = ST_RUN;
          end else begin
            state_nxt  = ST_SETTLE;
            settle_nxt = SETTLE_INIT;
          end
        end
      end
      ST_SETTLE: begin
        if (wr.Commit) begin
          state_nxt = ST_ARMED;
        end else if (vs_edge) begin
          if (settle_cnt == 4'd0) state_nxt = ST_RUN;
          else                    settle_nxt = settle_cnt - 4'd1;
        end
      end
      ST_RUN: begin
        if (wr.Commit) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_POS; i++) shadow_pos[i] <= 24'h0;
      shadow_delay <= DEF_DELAY;
      shadow_strum <= DEF_STRUM;
      dirty        <= 1'b0;
    end else if (load) begin
      dirty <= 1'b0;
    end else if (wr_fire) begin
      case (wr.WrAddr)
        ADDR_G, ADDR_R, ADDR_Y, ADDR_B, ADDR_O: begin
          shadow_pos[wr.WrAddr] <= wr.WrData & POS_MASK;
          dirty                 <= 1'b1;
        end
        ADDR_DELAY: begin
          shadow_delay <= wr.WrData[4:0];
          dirty        <= 1'b1;
        end
        ADDR_STRUM: begin
          shadow_strum <= wr.WrData[3:0];
          dirty        <= 1'b1;
        end
        ADDR_RSVD: begin
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_POS; i++) active_pos[i] <= 24'h0;
      active_delay <= DEF_DELAY;
      active_strum <= DEF_STRUM;
    end else if (load) begin
      for (int i = 0; i < NUM_POS; i++) active_pos[i] <= shadow_pos[i];
      active_delay <= shadow_delay;
      active_strum <= shadow_strum;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)          frame_cnt <= '0;
    else if (vs_edge) frame_cnt <= frame_cnt + FCNT_W'(1);
  end

  assign GreenPos   = active_pos[0];
  assign RedPos     = active_pos[1];
  assign YellowPos  = active_pos[2];
  assign BluePos    = active_pos[3];
  assign OrangePos  = active_pos[4];
  assign DelayValue = active_delay;
  assign StrumTime  = active_strum;
  assign Enable     = (state == ST_RUN) & EnableReq;
  assign FrameCount = frame_cnt;
  assign Status     = {state, (state == ST_ARMED), dirty};

endmodule
`default_nettype wire

// File: tb/tb_player_cfg_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_player_cfg_sequencer : directed scoreboard bench for the sequencer   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_player_cfg_sequencer;

  logic clk;
  logic rst;
  logic vsync;
  logic enable_req;

  player_cfg_sequencer_if wr1 ();
  player_cfg_sequencer_if wr2 ();

  logic [23:0] green, red, yellow, blue, orange;
  logic [4:0]  delay_v;
  logic [3:0]  strum_v;
  logic        enable;
  logic [15:0] fcount;
  logic [3:0]  status;

  logic [23:0] green2, red2, yellow2, blue2, orange2;
  logic [4:0]  delay2;
  logic [3:0]  strum2;
  logic        enable2;
  logic [3:0]  fcount2;
  logic [3:0]  status2;

  player_cfg_sequencer #(
    .SETTLE_FRAMES (4),
    .DEF_DELAY     (5'd0),
    .DEF_STRUM     (4'd3),
    .FCNT_W        (16)
  ) u_dut (
    .CLK (clk), .RST (rst), .VSync (vsync), .wr (wr1), .EnableReq (enable_req),
    .GreenPos (green), .RedPos (red), .YellowPos (yellow), .BluePos (blue),
    .OrangePos (orange), .DelayValue (delay_v), .StrumTime (strum_v),
    .Enable (enable), .FrameCount (fcount), .Status (status)
  );

  // Narrow counter and single-frame settle exercise wrap and direct-to-RUN.
  player_cfg_sequencer #(
    .SETTLE_FRAMES (1),
    .DEF_DELAY     (5'd0),
    .DEF_STRUM     (4'd3),
    .FCNT_W        (4)
  ) u_dut_wrap (
    .CLK (clk), .RST (rst), .VSync (vsync), .wr (wr2), .EnableReq (enable_req),
    .GreenPos (green2), .RedPos (red2), .YellowPos (yellow2), .BluePos (blue2),
    .OrangePos (orange2), .DelayValue (delay2), .StrumTime (strum2),
    .Enable (enable2), .FrameCount (fcount2), .Status (status2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   fc_model = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] exp_v, input logic [31:0] obs);
    push_exp(tag, exp_v);
    pop_cmp(obs);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [23:0] d);
    logic accepted;
    accepted    = 1'b0;
    wr1.WrValid = 1'b1;
    wr1.WrAddr  = a;
    wr1.WrData  = d;
    for (int i = 0; i < 20 && !accepted; i++) begin
      if (wr1.WrReady) accepted = 1'b1;
      tick();
    end
    wr1.WrValid = 1'b0;
    chk("wr_handshake", 32'd1, 32'(accepted));
  endtask

  task automatic do_commit();
    wr1.Commit = 1'b1;
    tick();
    wr1.Commit = 1'b0;
  endtask

  task automatic frame();
    vsync = 1'b1;
    tick();
    tick();
    fc_model++;
    vsync = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    vsync       = 1'b0;
    enable_req  = 1'b1;
    wr1.WrValid = 1'b0; wr1.WrAddr = 3'd0; wr1.WrData = 24'h0; wr1.Commit = 1'b0;
    wr2.WrValid = 1'b0; wr2.WrAddr = 3'd0; wr2.WrData = 24'h0; wr2.Commit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_green",  32'h0, 32'(green));
    chk("rst_orange", 32'h0, 32'(orange));
    chk("rst_delay",  32'h0, 32'(delay_v));
    chk("rst_strum",  32'h3, 32'(strum_v));
    chk("rst_enable", 32'h0, 32'(enable));
    chk("rst_fcount", 32'h0, 32'(fcount));
    chk("rst_status", 32'h0, 32'(status));
    chk("rst_ready",  32'h1, 32'(wr1.WrReady));

    // Green write, commit, apply on the frame edge, then a 4-frame settle.
    do_write(3'd0, 24'h0C8064);
    chk("t1_status_dirty", 32'h1, 32'(status));
    wr2.Commit = 1'b1;
    do_commit();
    wr2.Commit = 1'b0;
    chk("t1_status_armed", 32'h7, 32'(status));
    chk("t1_ready_armed",  32'h0, 32'(wr1.WrReady));
    push_exp("t1_green_at_k",  32'h0);
    push_exp("t1_green_at_k1", 32'h0C8064);
    vsync = 1'b1;
    tick();
    pop_cmp(32'(green));
    tick();
    pop_cmp(32'(green));
    fc_model++;
    chk("t1_status_settle", 32'h8, 32'(status));
    chk("t1_fcount",        32'(fc_model), 32'(fcount));
    chk("t1_wrap_dut_run",  32'hC, 32'(status2));
    chk("t1_wrap_dut_en",   32'h1, 32'(enable2));
    vsync = 1'b0;
    tick();
    tick();
    for (int f = 0; f < 3; f++) begin
      frame();
      chk("t1_settle_enable", 32'h0, 32'(enable));
    end
    frame();
    chk("t1_status_run", 32'hC, 32'(status));
    chk("t1_enable_run", 32'h1, 32'(enable));
    enable_req = 1'b0;
    #1;
    chk("t1_enable_req_low", 32'h0, 32'(enable));
    chk("t1_status_hold",    32'hC, 32'(status));
    enable_req = 1'b1;
    #1;
    chk("t1_fcount_5", 32'(fc_model), 32'(fcount));

    // Reserved address is accepted without effect; position data is masked.
    do_write(3'd7, 24'h123456);
    chk("t2_rsvd_not_dirty", 32'hC, 32'(status));
    do_write(3'd3, 24'hFFFFFF);
    chk("t2_dirty", 32'hD, 32'(status));
    do_write(3'd5, 24'hFFFFE3);
    do_write(3'd6, 24'hFFFFFA);
    do_commit();
    chk("t2_status_armed", 32'h7, 32'(status));
    chk("t2_enable_drop",  32'h0, 32'(enable));
    chk("t2_blue_pending", 32'h0, 32'(blue));

    // Held write while ARMED stalls, then lands the cycle after the apply edge.
    wr1.WrValid = 1'b1;
    wr1.WrAddr  = 3'd1;
    wr1.WrData  = 24'h111111;
    tick();
    tick();
    chk("t3_ready_low",  32'h0, 32'(wr1.WrReady));
    chk("t3_status",     32'h7, 32'(status));
    vsync = 1'b1;
    tick();
    chk("t3_ready_at_k", 32'h0, 32'(wr1.WrReady));
    tick();
    fc_model++;
    chk("t3_blue_masked", 32'h3FF7FF, 32'(blue));
    chk("t3_delay",       32'h3, 32'(delay_v));
    chk("t3_strum",       32'hA, 32'(strum_v));
    chk("t3_red_not_yet", 32'h0, 32'(red));
    chk("t3_green_kept",  32'h0C8064, 32'(green));
    chk("t3_status_clean", 32'h8, 32'(status));
    chk("t3_ready_high",  32'h1, 32'(wr1.WrReady));
    tick();
    wr1.WrValid = 1'b0;
    chk("t3_write_landed", 32'h9, 32'(status));
    vsync = 1'b0;
    tick();
    tick();

    // Commit in the vs_edge cycle waits for the following edge.
    vsync = 1'b1;
    tick();
    wr1.Commit = 1'b1;
    tick();
    wr1.Commit = 1'b0;
    fc_model++;
    chk("t4_red_unchanged", 32'h0, 32'(red));
    chk("t4_status_armed",  32'h7, 32'(status));
    chk("t4_fcount",        32'(fc_model), 32'(fcount));
    vsync = 1'b0;
    tick();
    tick();
    frame();
    chk("t4_red_applied", 32'h111111, 32'(red));
    chk("t4_status",      32'h8, 32'(status));

    // Commit mid-settle restarts a full settle after the next edge.
    frame();
    frame();
    chk("t5_mid_settle", 32'h8, 32'(status));
    do_commit();
    chk("t5_rearmed", 32'h6, 32'(status));
    frame();
    chk("t5_settle_again", 32'h8, 32'(status));
    for (int f = 0; f < 3; f++) begin
      frame();
      chk("t5_settle_enable", 32'h0, 32'(enable));
    end
    frame();
    chk("t5_run",    32'hC, 32'(status));
    chk("t5_enable", 32'h1, 32'(enable));
    frame();
    chk("t5_fcount16",  32'(fc_model), 32'(fcount));
    chk("t5_fcnt_wrap", 32'(fc_model % 16), 32'(fcount2));

    // Reset while ARMED with a dirty shadow discards the pending commit.
    do_write(3'd2, 24'h0ABCDE);
    do_commit();
    chk("t6_armed", 32'h7, 32'(status));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fc_model = 0;
    chk("t6_green",  32'h0, 32'(green));
    chk("t6_blue",   32'h0, 32'(blue));
    chk("t6_red",    32'h0, 32'(red));
    chk("t6_delay",  32'h0, 32'(delay_v));
    chk("t6_strum",  32'h3, 32'(strum_v));
    chk("t6_enable", 32'h0, 32'(enable));
    chk("t6_fcount", 32'h0, 32'(fcount));
    chk("t6_status", 32'h0, 32'(status));
    chk("t6_ready",  32'h1, 32'(wr1.WrReady));
    frame();
    chk("t6_yellow_after", 32'h0, 32'(yellow));
    chk("t6_green_after",  32'h0, 32'(green));
    chk("t6_status_after", 32'h0, 32'(status));
    chk("t6_fcount_after", 32'(fc_model), 32'(fcount));

    n_cmp++;
    if (sbq.size() != 0) begin
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
